// File: rtl/sig_delay_line.sv
// Programmable-delay sample line with warm-up muting, offset-0 bypass and glitch-free delay changes.
// Define SIG_DELAY_ECHO_EN to feed the attenuated tap back into the buffer (echo mode).
module sig_delay_line #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 9,
   parameter int unsigned FB_SHIFT      = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [ADDRESS_WIDTH-1:0] offset,
   input  logic [DATA_WIDTH-1:0]    mic_signal,
   output logic [DATA_WIDTH-1:0]    delayed_signal,
   output logic                     out_valid,
   output logic                     primed
);

   localparam int unsigned Depth = 1 << ADDRESS_WIDTH;

   if (FB_SHIFT == 0 || FB_SHIFT >= DATA_WIDTH) begin : g_bad_fb_shift
      $error("FB_SHIFT must be in 1..DATA_WIDTH-1");
   end

   logic [DATA_WIDTH-1:0]    mem_q [Depth];

   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] active_off_q, active_off_d;
   logic [ADDRESS_WIDTH-1:0] fill_q, fill_d;
   logic [DATA_WIDTH-1:0]    delayed_q, delayed_d;
   logic                     out_valid_q, out_valid_d;

   logic [ADDRESS_WIDTH-1:0] fill_eff;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0]    tap;
   logic [DATA_WIDTH-1:0]    store;
   logic                     bypass;

   // A delay change restarts warm-up on the very sample that carries it.
   always_comb begin
      fill_eff = (offset != active_off_q) ? '0 : fill_q;
      rd_addr  = wr_ptr_q - offset;
      tap      = (fill_eff >= offset) ? mem_q[rd_addr] : '0;
      bypass   = (offset == '0);
   end

`ifdef SIG_DELAY_ECHO_EN
   logic signed [DATA_WIDTH-1:0] fb;
   logic signed [DATA_WIDTH:0]   sum;

   always_comb begin
      fb    = $signed(tap) >>> FB_SHIFT;
      sum   = $signed({mic_signal[DATA_WIDTH-1], mic_signal}) + $signed({fb[DATA_WIDTH-1], fb});
      store = sum[DATA_WIDTH-1:0];
      // Sign bits disagree only on overflow; clamp to the representable range.
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
         store = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      if (bypass) begin
         store = mic_signal;
      end
   end
`else
   always_comb begin
      store = mic_signal;
   end
`endif

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      active_off_d = active_off_q;
      fill_d       = fill_q;
      delayed_d    = delayed_q;
      out_valid_d  = 1'b0;
      if (en) begin
         active_off_d = offset;
         wr_ptr_d     = wr_ptr_q + 1'b1;
         fill_d       = (fill_eff == offset) ? fill_eff : fill_eff + 1'b1;
         delayed_d    = bypass ? mic_signal : tap;
         out_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         active_off_q <= '0;
         fill_q       <= '0;
         delayed_q    <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         active_off_q <= active_off_d;
         fill_q       <= fill_d;
         delayed_q    <= delayed_d;
         out_valid_q  <= out_valid_d;
      end
   end

   // Storage is deliberately unreset; muting hides stale contents.
   always_ff @(posedge clk) begin
      if (en) begin
         mem_q[wr_ptr_q] <= store;
      end
   end

   assign delayed_signal = delayed_q;
   assign out_valid      = out_valid_q;
   assign primed         = (active_off_q == '0) || (fill_q == active_off_q);

endmodule

// File: tb/tb_sig_delay_line.sv
// Directed self-checking bench for sig_delay_line: warm-up, bypass, strobing, delay change,
// pointer wrap on a small instance, and echo mode when SIG_DELAY_ECHO_EN is defined.
module tb_sig_delay_line;

   logic       clk;
   logic       rst;
   logic       en;
   logic [8:0] offset;
   logic [7:0] mic_signal;
   logic [7:0] delayed_signal;
   logic       out_valid;
   logic       primed;

   logic       en_s;
   logic [2:0] offset_s;
   logic [7:0] mic_s;
   logic [7:0] delayed_s;
   logic       out_valid_s;
   logic       primed_s;

   int n_cmp;
   int n_mis;

   sig_delay_line #(
      .DATA_WIDTH   (8),
      .ADDRESS_WIDTH(9),
      .FB_SHIFT     (1)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .offset        (offset),
      .mic_signal    (mic_signal),
      .delayed_signal(delayed_signal),
      .out_valid     (out_valid),
      .primed        (primed)
   );

   sig_delay_line #(
      .DATA_WIDTH   (8),
      .ADDRESS_WIDTH(3),
      .FB_SHIFT     (1)
   ) u_small (
      .clk           (clk),
      .rst           (rst),
      .en            (en_s),
      .offset        (offset_s),
      .mic_signal    (mic_s),
      .delayed_signal(delayed_s),
      .out_valid     (out_valid_s),
      .primed        (primed_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic e, input logic [8:0] off, input logic [7:0] m);
      en         = e;
      offset     = off;
      mic_signal = m;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_s(input logic e, input logic [2:0] off, input logic [7:0] m);
      en_s     = e;
      offset_s = off;
      mic_s    = m;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      en   = 1'b0;
      en_s = 1'b0;
      rst  = 1'b0;
      #1;
      chk("rst_async_out", {24'd0, delayed_signal}, 32'd0);
      chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_async_primed", {31'd0, primed}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] held;
      n_cmp      = 0;
      n_mis      = 0;
      rst        = 1'b0;
      en         = 1'b0;
      offset     = '0;
      mic_signal = '0;
      en_s       = 1'b0;
      offset_s   = '0;
      mic_s      = '0;

      // Reset state before any clock edge.
      #2;
      chk("reset_out", {24'd0, delayed_signal}, 32'd0);
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_primed", {31'd0, primed}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Offset 4, continuous strobes, samples 1..10 -> 0,0,0,0,1,2,...
      for (int i = 1; i <= 10; i++) begin
         strobe(1'b1, 9'd4, 8'(i));
         chk("warm4_out", {24'd0, delayed_signal}, (i >= 5) ? 32'(i - 4) : 32'd0);
         chk("warm4_valid", {31'd0, out_valid}, 32'd1);
         chk("warm4_primed", {31'd0, primed}, (i >= 4) ? 32'd1 : 32'd0);
      end

      // Change to offset 2 mid-stream: two muted outputs then 11,12,...
      for (int i = 1; i <= 6; i++) begin
         strobe(1'b1, 9'd2, 8'(10 + i));
         chk("chg2_out", {24'd0, delayed_signal}, (i >= 3) ? 32'(8 + i) : 32'd0);
         chk("chg2_primed", {31'd0, primed}, (i >= 2) ? 32'd1 : 32'd0);
      end

      // Bypass.
      strobe(1'b1, 9'd0, 8'h5A);
      chk("bypass_out", {24'd0, delayed_signal}, 32'h5A);
      chk("bypass_primed", {31'd0, primed}, 32'd1);
      chk("bypass_valid", {31'd0, out_valid}, 32'd1);
      strobe(1'b1, 9'd0, 8'h33);
      chk("bypass_out2", {24'd0, delayed_signal}, 32'h33);
      strobe(1'b0, 9'd0, 8'hEE);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_hold", {24'd0, delayed_signal}, 32'h33);

      // Offset 3 strobed every third cycle, inputs 10,20,30,40 -> 0,0,0,10.
      for (int i = 1; i <= 4; i++) begin
         held = (i == 4) ? 8'd10 : 8'd0;
         strobe(1'b1, 9'd3, 8'(10 * i));
         chk("slow3_out", {24'd0, delayed_signal}, {24'd0, held});
         chk("slow3_valid", {31'd0, out_valid}, 32'd1);
         for (int k = 0; k < 2; k++) begin
            strobe(1'b0, 9'd3, 8'hFF);
            chk("slow3_gap_valid", {31'd0, out_valid}, 32'd0);
            chk("slow3_gap_hold", {24'd0, delayed_signal}, {24'd0, held});
         end
      end
      chk("slow3_primed", {31'd0, primed}, 32'd1);

      // Mid-stream reset, then warm-up repeats at offset 2.
      pulse_reset();
      for (int i = 1; i <= 4; i++) begin
         strobe(1'b1, 9'd2, 8'(50 + i));
         chk("post_rst_out", {24'd0, delayed_signal}, (i >= 3) ? 32'(48 + i) : 32'd0);
      end
      en = 1'b0;

      // Small instance: depth 8, offset 7, pointer wraps 7->0.
      for (int i = 1; i <= 20; i++) begin
         strobe_s(1'b1, 3'd7, 8'(i));
         chk("wrap7_out", {24'd0, delayed_s}, (i >= 8) ? 32'(i - 7) : 32'd0);
         chk("wrap7_primed", {31'd0, primed_s}, (i >= 7) ? 32'd1 : 32'd0);
      end
      en_s = 1'b0;

`ifdef SIG_DELAY_ECHO_EN
      // Impulse 100 at offset 2, feedback halves each pass.
      pulse_reset();
      begin
         logic [7:0] echo_exp [7];
         echo_exp = '{8'd0, 8'd0, 8'd100, 8'd0, 8'd50, 8'd0, 8'd25};
         for (int i = 0; i < 7; i++) begin
            strobe(1'b1, 9'd2, (i == 0) ? 8'd100 : 8'd0);
            chk("echo_out", {24'd0, delayed_signal}, {24'd0, echo_exp[i]});
         end
      end
      // 127 + (127 >>> 1) saturates to 127.
      pulse_reset();
      begin
         logic [7:0] sat_exp [4];
         sat_exp = '{8'd0, 8'd127, 8'd127, 8'd63};
         for (int i = 0; i < 4; i++) begin
            strobe(1'b1, 9'd1, (i < 2) ? 8'd127 : 8'd0);
            chk("echo_sat", {24'd0, delayed_signal}, {24'd0, sat_exp[i]});
         end
      end
      en = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/sig_delay_line.md
# sig_delay_line

Programmable-delay audio sample line for the signal-generator/microphone path. Successor to the fixed RAM-plus-counter delay: parametrised width and depth, sample-strobe driven, with warm-up muting so stale memory never reaches the output, glitch-free delay changes, an offset-0 bypass, and an optional echo (feedback) mode. Sits between the mic/ADC sample source and the DAC/output stage.

## Interface
Parameters:
- `DATA_WIDTH`, 8: sample width, signed two's complement.
- `ADDRESS_WIDTH`, 9: buffer depth = 2^ADDRESS_WIDTH samples; max delay 2^ADDRESS_WIDTH−1.
- `FB_SHIFT`, 1: feedback attenuation, arithmetic right shift (echo mode only); legal 1..DATA_WIDTH−1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `en` in 1: sample strobe; one input sample consumed per cycle with `en`=1.
- `offset` in ADDRESS_WIDTH: requested delay in samples; sampled only on `en` cycles.
- `mic_signal` in DATA_WIDTH: input sample.
- `delayed_signal` out DATA_WIDTH: delayed (or muted/bypassed) sample, registered.
- `out_valid` out 1: one-cycle pulse marking a new `delayed_signal`.
- `primed` out 1: high when the buffer holds ≥ active-delay valid samples.

## Operation
- Internal state: `wr_ptr` (ADDRESS_WIDTH), `active_off` (ADDRESS_WIDTH), `fill` (ADDRESS_WIDTH, saturating), storage array 2^ADDRESS_WIDTH × DATA_WIDTH (not reset).
- Per `en` cycle, in order:
  1. If `offset` ≠ `active_off`: `active_off` ← `offset`, `fill` ← 0 (this sample counts as the first: next value 1). Delay change takes effect on this sample.
  2. Read address = `wr_ptr` − new `active_off`, modulo 2^ADDRESS_WIDTH (natural wrap). Array read combinational.
  3. Tap value `tap` = array[rd_addr] if `fill` (pre-increment) ≥ `active_off`, else 0 (muted).
  4. Write array[`wr_ptr`] ← store value (see below); `wr_ptr` ← `wr_ptr`+1, wraps 2^ADDRESS_WIDTH−1 → 0.
  5. `fill` ← min(`fill`+1, `active_off`).
  6. `delayed_signal` ← `tap`; `out_valid` ← 1.
- Store value = `mic_signal` (echo disabled).
- Offset 0 = bypass: `delayed_signal` ← `mic_signal`, `primed`=1, no muting; write still occurs.
- `primed` = (`active_off`=0) or (`fill` = `active_off`) — combinational on registered state.
- No read/write collision: read address equals write address only when `active_off`=0, which bypasses the array.
- `en`=0: all state and `delayed_signal` hold; `out_valid` ← 0.

## Timing
- Reset (`rst`=0, asynchronous): `delayed_signal`=0, `out_valid`=0, `wr_ptr`=0, `fill`=0, `active_off`=0 (so `primed`=1 during reset). Array contents undefined; muting covers them.
- Latency: sample on `en` at edge t appears on `delayed_signal` with `out_valid`=1 after edge t (one cycle) when delayed by 0; with delay D it appears on the output D strobes later, same one-cycle pipeline.
- `en` may be held high continuously (one sample/cycle) or strobed at any rate; delay is counted in strobes, not cycles.
- After reset or offset change to D>0: first D outputs are 0, output D+1 onward carries real data; `primed` rises on the edge that writes the D-th sample.
- Reset mid-stream: outputs clear immediately; pointers restart at 0; warm-up repeats.

## Configuration
- `SIG_DELAY_ECHO_EN` defined: store value = saturate(`mic_signal` + (`tap` >>> `FB_SHIFT`)), computed in DATA_WIDTH+1 bits, clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. Output remains `tap` (pure echo tail). Muted taps feed back 0. In bypass (`active_off`=0) feedback is disabled: store = `mic_signal`.
- Not defined: store value = `mic_signal`; no adder or saturation logic synthesised.

## Test plan
- Reset then `offset`=4, `en`=1 continuously, `mic_signal`=1,2,3,… → `delayed_signal` 0,0,0,0,1,2,3…; `primed` high after 4th strobe; `out_valid` high every cycle.
- `offset`=0, input 0x5A → next cycle `delayed_signal`=0x5A, `primed`=1.
- `offset`=3 with `en` strobed every 3rd cycle, inputs 10,20,30,40 → output 10 on 4th strobe; output and `out_valid` hold/0 between strobes.
- Primed at `offset`=4, change to `offset`=2 mid-stream → two muted 0 outputs, then samples delayed by 2; `primed` drops then re-rises.
- `ADDRESS_WIDTH`=3, `offset`=7, 20 incrementing samples → correct delay across `wr_ptr` wrap 7→0, output = input−7.
- `SIG_DELAY_ECHO_EN`, `FB_SHIFT`=1, `offset`=2, impulse 100 then zeros → outputs 0,0,100(at strobe 3),0,50,0,25…; input 127 plus tap 127 → stored 127 (saturated).
